adder_tree_operand_loader: RTL
==============================

Name: adder_tree_operand_loader

Overview:
- Front end for the registered 8-input adder tree.
- Accepts operands serially, one word per cycle, over a valid/ready handshake.
- Assembles groups of NUM_OPERANDS words and launches each group as one parallel bus that drives the tree's operand inputs.
- Tracks tree latency so a `sum_valid` strobe lines up with the tree's registered sum, and counts launched groups.

Parameters:
- ADDER_WIDTH, 28, width of each operand word.
- NUM_OPERANDS, 8, words per group. Must be a power of two, at least 2.
- TREE_LATENCY, 2, clk cycles from a `launch` pulse to the tree's sum register holding that group's sum.
- CNT_WIDTH, 16, width of the launched-group counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  ADDER_WIDTH  serial operand word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a word this cycle.
- hold  in  1  downstream stall; while 1, no launch occurs.
- ops  out  NUM_OPERANDS*ADDER_WIDTH  parallel operands; operand k is at bits [k*ADDER_WIDTH +: ADDER_WIDTH].
- launch  out  1  one-cycle pulse: ops updated this cycle.
- sum_valid  out  1  tree sum for a launched group is valid this cycle.
- group_count  out  CNT_WIDTH  number of groups launched.
- fill_level  out  log2(NUM_OPERANDS)+1  words currently held in the collect bank.

Behaviour:
- Reset (async assert, sync deassert by the system) clears:
  - state to COLLECT
  - index and fill_level to 0
  - ops to all 0
  - launch, sum_valid and the latency shift register to 0
  - group_count to 0
  - in_ready to 0 while rst=1
- A mid-group reset discards partial words. A reset with in-flight sum_valid bits drops them, so no strobe is emitted after reset.
- A word is accepted when in_valid && in_ready. It is written to bank[index], then index increments.
- State COLLECT:
  - in_ready=1.
  - On accepting the word with index==NUM_OPERANDS-1:
    - if hold=0: ops <= bank with the new word merged, launch=1 next cycle, index <= 0, stay in COLLECT. There is no bubble, so back-to-back groups are sustained at 1 word/cycle.
    - if hold=1: go to FULL.
- State FULL:
  - in_ready=0.
  - On the first cycle with hold=0: ops <= bank, launch pulse, index <= 0, go to COLLECT.
  - in_ready returns to 1 on the cycle after the launch.
- Width and timing rules:
  - ops is registered and changes only on launch edges. Otherwise it holds its value.
  - launch is asserted in the same cycle ops first shows the new group.
  - sum_valid equals launch delayed by exactly TREE_LATENCY cycles, through a shift register with no gaps or merging.
  - group_count increments on each launch and wraps modulo 2^CNT_WIDTH, so all-ones becomes 0.
  - fill_level equals index in COLLECT and NUM_OPERANDS in FULL.
- Boundaries:
  - in_valid=0 mid-group: the bank holds and index is unchanged. No timeout.
  - hold toggling while collecting does not stall input before the final word.
  - No data is dropped or duplicated under any hold pattern.

Optional Feature:
- Macro: OPERAND_LOADER_FLUSH_EN.
- When defined, adds input port `flush` (1 bit).
  - flush=1 in COLLECT with index>0 launches a partial group: unfilled slots are zero, and launch, sum_valid and group_count behave as for a full group. It obeys hold in the same way, via FULL.
  - A word accepted in the same cycle as flush is included in the group.
  - flush with index==0 is ignored.
- When undefined: there is no flush port, and only full groups are launched.

Test Plan:
- Reset, then stream words 1..8 with hold=0 → launch in the cycle after word 8. ops = {8,7,...,1} (operand k = k+1). sum_valid 2 cycles after launch. group_count=1.
- Stream 16 words back-to-back with no gaps → two launch pulses 8 cycles apart. in_ready is never 0. sum_valid pulses 8 cycles apart.
- hold=1 across word 8, released 5 cycles later → in_ready=0 and fill_level=8 during the hold. launch occurs on the release edge. ops is unchanged before launch.
- Assert rst after 5 words accepted and with one sum_valid in flight → all outputs 0, no sum_valid afterwards. The next 8 words form a clean group.
- Preload group_count to all-ones by launching 65535 groups, then one more launch → group_count wraps to 0.
- With OPERAND_LOADER_FLUSH_EN: 3 words 0xFFFFFFF, then flush=1 → launch. Operands 0..2 = 0xFFFFFFF, operands 3..7 = 0.

Source files
------------

// File: rtl/adder_tree_operand_loader.sv
// Serial-to-parallel operand loader for the registered adder tree, with launch/sum_valid timing.
// Optional partial-group flush is enabled by defining OPERAND_LOADER_FLUSH_EN.
module adder_tree_operand_loader #(
    parameter int unsigned ADDER_WIDTH  = 28,
    parameter int unsigned NUM_OPERANDS = 8,
    parameter int unsigned TREE_LATENCY = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDER_WIDTH-1:0]              in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                hold,
`ifdef OPERAND_LOADER_FLUSH_EN
    input  logic                                flush,
`endif
    output logic [NUM_OPERANDS*ADDER_WIDTH-1:0] ops,
    output logic                                launch,
    output logic                                sum_valid,
    output logic [CNT_WIDTH-1:0]                group_count,
    output logic [$clog2(NUM_OPERANDS):0]       fill_level
);

    localparam int unsigned IDX_W = $clog2(NUM_OPERANDS) + 1;

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t                              state;
    state_t                              state_next;
    logic [ADDER_WIDTH-1:0]              bank [NUM_OPERANDS];
    logic [IDX_W-1:0]                    index;
    logic [IDX_W-1:0]                    count_new;
    logic [IDX_W-1:0]                    launch_count;
    logic [TREE_LATENCY-1:0]             lat_sr;
    logic [NUM_OPERANDS*ADDER_WIDTH-1:0] launch_bus;
    logic                                accept;
    logic                                flush_req;
    logic                                group_done;
    logic                                do_launch;

    assign in_ready  = (state == COLLECT) && !rst;
    assign accept    = in_valid && in_ready;
    assign count_new = index + {{(IDX_W-1){1'b0}}, accept};

`ifdef OPERAND_LOADER_FLUSH_EN
    assign flush_req = flush && (index != '0);
`else
    assign flush_req = 1'b0;
`endif

    assign group_done = (state == COLLECT) &&
                        ((accept && (index == IDX_W'(NUM_OPERANDS - 1))) || flush_req);

    // In FULL, index keeps the group's word count so a held partial group launches correctly.
    assign fill_level = (state == FULL) ? IDX_W'(NUM_OPERANDS) : index;
    assign sum_valid  = lat_sr[TREE_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        do_launch    = 1'b0;
        launch_count = '0;
        case (state)
            COLLECT: begin
                if (group_done) begin
                    if (!hold) begin
                        do_launch    = 1'b1;
                        launch_count = count_new;
                    end else begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (!hold) begin
                    do_launch    = 1'b1;
                    launch_count = index;
                    state_next   = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Same-cycle word is merged in; slots beyond the group's count are zero-filled.
    always_comb begin
        launch_bus = '0;
        for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
            if (IDX_W'(k) < launch_count) begin
                if (accept && (IDX_W'(k) == index)) begin
                    launch_bus[k*ADDER_WIDTH +: ADDER_WIDTH] = in_data;
                end else begin
                    launch_bus[k*ADDER_WIDTH +: ADDER_WIDTH] = bank[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bank[index[IDX_W-2:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index       <= '0;
            ops         <= '0;
            launch      <= 1'b0;
            group_count <= '0;
            lat_sr      <= '0;
        end else begin
            launch    <= do_launch;
            lat_sr[0] <= launch;
            for (int unsigned i = 1; i < TREE_LATENCY; i++) begin
                lat_sr[i] <= lat_sr[i-1];
            end
            if (do_launch) begin
                ops         <= launch_bus;
                index       <= '0;
                group_count <= group_count + CNT_WIDTH'(1);
            end else begin
                index <= count_new;
            end
        end
    end

endmodule
